// File: rtl/de0_step_clock_gen.sv
// Debounced single-step / free-run datapath clock generator for the DE0 harness.
// Optional STEP_BURST_EN adds burst_len: each press yields burst_len+1 pulses.
module de0_step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned RUN_HALF        = 12500000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button_n,
  input  logic             run_sw,
`ifdef STEP_BURST_EN
  input  logic [3:0]       burst_len,
`endif
  output logic             dp_clock,
  output logic             step_pulse,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned RW  = (RUN_HALF > 1) ? $clog2(RUN_HALF) : 1;
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [RW-1:0]  RUN_LAST   = RW'(RUN_HALF - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_REL} state_t;

  state_t          state, next_state;
  logic            btn_s1, btn_s2, run_s1, run_s2;
  logic            db_level, press_evt;
  logic [DBW-1:0]  db_cnt;
  logic            mode_run, mode_run_d, mode_change;
  logic [RW-1:0]   div_cnt, div_cnt_d;
  logic            run_toggle;
  logic [PW-1:0]   pulse_cnt, pulse_cnt_d;
  logic [3:0]      burst_left, burst_left_d, burst_load;
  logic            dp_clock_d, step_pulse_d, busy_d;

`ifdef STEP_BURST_EN
  assign burst_load = burst_len;
`else
  assign burst_load = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      btn_s1 <= button_n;
      btn_s2 <= btn_s1;
      run_s1 <= run_sw;
      run_s2 <= run_s1;
    end
  end

  // db_level is 1 when released; press_evt strobes on the accepted release->press flip.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_level  <= 1'b1;
      db_cnt    <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (btn_s2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level  <= btn_s2;
          db_cnt    <= '0;
          press_evt <= ~btn_s2;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Mode may only change while dp_clock is low and no pulse or burst is in flight.
  assign mode_change = !dp_clock && (state == IDLE || state == WAIT_REL) && (run_s2 != mode_run);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mode_run    <= 1'b0;
      div_cnt     <= '0;
      pulse_cnt   <= '0;
      burst_left  <= '0;
      dp_clock    <= 1'b0;
      step_pulse  <= 1'b0;
      busy        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state      <= next_state;
      mode_run   <= mode_run_d;
      div_cnt    <= div_cnt_d;
      pulse_cnt  <= pulse_cnt_d;
      burst_left <= burst_left_d;
      dp_clock   <= dp_clock_d;
      step_pulse <= step_pulse_d;
      busy       <= busy_d;
      if (step_pulse_d) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state   = state;
    mode_run_d   = mode_run;
    div_cnt_d    = div_cnt;
    pulse_cnt_d  = pulse_cnt;
    burst_left_d = burst_left;
    run_toggle   = 1'b0;
    if (mode_change) begin
      mode_run_d = run_s2;
      div_cnt_d  = '0;
      if (run_s2) next_state = IDLE;
      else        next_state = db_level ? IDLE : WAIT_REL;
    end else if (mode_run) begin
      next_state = IDLE;
      if (div_cnt == RUN_LAST) begin
        div_cnt_d  = '0;
        run_toggle = 1'b1;
      end else begin
        div_cnt_d = div_cnt + RW'(1);
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (press_evt) begin
            next_state   = HIGH;
            pulse_cnt_d  = '0;
            burst_left_d = burst_load;
          end
        end
        HIGH: begin
          if (pulse_cnt == PULSE_LAST) begin
            pulse_cnt_d = '0;
            next_state  = (burst_left != '0) ? LOW : WAIT_REL;
          end else begin
            pulse_cnt_d = pulse_cnt + PW'(1);
          end
        end
        LOW: begin
          if (pulse_cnt == PULSE_LAST) begin
            pulse_cnt_d  = '0;
            burst_left_d = burst_left - 4'd1;
            next_state   = HIGH;
          end else begin
            pulse_cnt_d = pulse_cnt + PW'(1);
          end
        end
        WAIT_REL: begin
          if (db_level) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    dp_clock_d   = 1'b0;
    step_pulse_d = 1'b0;
    busy_d       = 1'b0;
    if (mode_run && !mode_change) begin
      dp_clock_d   = dp_clock ^ run_toggle;
      step_pulse_d = run_toggle & ~dp_clock;
    end else begin
      dp_clock_d   = (next_state == HIGH);
      step_pulse_d = (next_state == HIGH) && (state != HIGH);
      busy_d       = (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_de0_step_clock_gen.sv
// Directed self-checking bench for de0_step_clock_gen (DEBOUNCE=8, PULSE=4, RUN_HALF=5).
module tb_de0_step_clock_gen;

  logic        clock;
  logic        reset;
  logic        button_n;
  logic        run_sw;
  logic        dp_clock;
  logic        step_pulse;
  logic [15:0] cycle_count;
  logic        busy;
`ifdef STEP_BURST_EN
  logic [3:0]  burst_len;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  de0_step_clock_gen #(
    .DEBOUNCE_CYCLES(8),
    .PULSE_CYCLES(4),
    .RUN_HALF(5),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button_n(button_n),
    .run_sw(run_sw),
`ifdef STEP_BURST_EN
    .burst_len(burst_len),
`endif
    .dp_clock(dp_clock),
    .step_pulse(step_pulse),
    .cycle_count(cycle_count),
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    reset    = 1'b0;
    button_n = 1'b1;
    run_sw   = 1'b0;
`ifdef STEP_BURST_EN
    burst_len = 4'd0;
`endif
    tick(2);
    chk("rst_dp", 32'(dp_clock), 32'd0);
    chk("rst_sp", 32'(step_pulse), 32'd0);
    chk("rst_cnt", 32'(cycle_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick(3);

    // clean press held 40 cycles
    button_n = 1'b0;
    tick(10);
    chk("t1_pre_dp", 32'(dp_clock), 32'd0);
    tick(1);
    chk("t1_rise_dp", 32'(dp_clock), 32'd1);
    chk("t1_rise_sp", 32'(step_pulse), 32'd1);
    chk("t1_rise_cnt", 32'(cycle_count), 32'd1);
    chk("t1_rise_busy", 32'(busy), 32'd1);
    tick(1);
    chk("t1_sp_once", 32'(step_pulse), 32'd0);
    chk("t1_hi2", 32'(dp_clock), 32'd1);
    tick(2);
    chk("t1_hi4", 32'(dp_clock), 32'd1);
    tick(1);
    chk("t1_fall", 32'(dp_clock), 32'd0);
    chk("t1_busy_held", 32'(busy), 32'd1);
    tick(25);
    chk("t1_hold_dp", 32'(dp_clock), 32'd0);
    chk("t1_hold_cnt", 32'(cycle_count), 32'd1);
    button_n = 1'b1;
    tick(10);
    chk("t1_rel_busy1", 32'(busy), 32'd1);
    tick(1);
    chk("t1_rel_busy0", 32'(busy), 32'd0);
    chk("t1_rel_cnt", 32'(cycle_count), 32'd1);

    // bounce every 3 cycles, then settle low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      button_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
      chk("t2_bounce_dp", 32'(dp_clock), 32'd0);
    end
    button_n = 1'b0;
    tick(10);
    chk("t2_pre_dp", 32'(dp_clock), 32'd0);
    chk("t2_pre_cnt", 32'(cycle_count), 32'd0);
    tick(1);
    chk("t2_rise_dp", 32'(dp_clock), 32'd1);
    chk("t2_rise_cnt", 32'(cycle_count), 32'd1);
    tick(5);
    button_n = 1'b1;
    tick(15);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // free-run mode, presses ignored
    do_reset();
    run_sw = 1'b1;
    tick(7);
    chk("t3_pre_dp", 32'(dp_clock), 32'd0);
    tick(1);
    chk("t3_rise1_dp", 32'(dp_clock), 32'd1);
    chk("t3_rise1_sp", 32'(step_pulse), 32'd1);
    chk("t3_rise1_cnt", 32'(cycle_count), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick(1);
      chk("t3_sp_low", 32'(step_pulse), 32'd0);
      chk("t3_hi", 32'(dp_clock), 32'd1);
      tick(4);
      chk("t3_fall", 32'(dp_clock), 32'd0);
      tick(5);
      chk("t3_rise_dp", 32'(dp_clock), 32'd1);
      chk("t3_rise_sp", 32'(step_pulse), 32'd1);
      chk("t3_rise_cnt", 32'(cycle_count), 32'(k));
      chk("t3_busy", 32'(busy), 32'd0);
      if (k == 3) button_n = 1'b0;
      if (k == 5) button_n = 1'b1;
    end

    // switch to step during the high phase
    run_sw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t4_hi_kept", 32'(dp_clock), 32'd1);
    end
    tick(1);
    chk("t4_fall", 32'(dp_clock), 32'd0);
    tick(7);
    chk("t4_no_run_dp", 32'(dp_clock), 32'd0);
    tick(13);
    chk("t4_no_run_cnt", 32'(cycle_count), 32'd8);
    button_n = 1'b0;
    tick(10);
    chk("t4_pre_dp", 32'(dp_clock), 32'd0);
    tick(1);
    chk("t4_step_dp", 32'(dp_clock), 32'd1);
    chk("t4_step_cnt", 32'(cycle_count), 32'd9);
    tick(5);
    button_n = 1'b1;
    tick(15);

    // reset during the 2nd cycle of a pulse
    do_reset();
    button_n = 1'b0;
    tick(11);
    chk("t5_rise", 32'(dp_clock), 32'd1);
    tick(1);
    chk("t5_hi2", 32'(dp_clock), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_dp", 32'(dp_clock), 32'd0);
    chk("t5_async_cnt", 32'(cycle_count), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    button_n = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(30);
    chk("t5_no_resume_dp", 32'(dp_clock), 32'd0);
    chk("t5_no_resume_cnt", 32'(cycle_count), 32'd0);
    button_n = 1'b0;
    tick(11);
    chk("t5_new_dp", 32'(dp_clock), 32'd1);
    chk("t5_new_cnt", 32'(cycle_count), 32'd1);
    tick(5);
    button_n = 1'b1;
    tick(15);

`ifdef STEP_BURST_EN
    // burst of three pulses, burst_len latched at the press
    do_reset();
    burst_len = 4'd2;
    button_n  = 1'b0;
    tick(11);
    burst_len = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      chk("t6_rise_dp", 32'(dp_clock), 32'd1);
      chk("t6_rise_sp", 32'(step_pulse), 32'd1);
      chk("t6_rise_cnt", 32'(cycle_count), 32'(k));
      chk("t6_busy", 32'(busy), 32'd1);
      tick(3);
      chk("t6_hi4", 32'(dp_clock), 32'd1);
      tick(1);
      chk("t6_low", 32'(dp_clock), 32'd0);
      chk("t6_low_busy", 32'(busy), 32'd1);
      if (k < 3) tick(4);
    end
    tick(10);
    chk("t6_done_dp", 32'(dp_clock), 32'd0);
    chk("t6_done_cnt", 32'(cycle_count), 32'd3);
    chk("t6_held_busy", 32'(busy), 32'd1);
    button_n = 1'b1;
    tick(10);
    chk("t6_rel_busy1", 32'(busy), 32'd1);
    tick(1);
    chk("t6_rel_busy0", 32'(busy), 32'd0);
    chk("t6_rel_cnt", 32'(cycle_count), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
